// File: rtl/cuckoo_access_controller.sv
// cuckoo_access_controller
// Sequences lookup / insert / delete requests on a two-table cuckoo hash. Each pass reads the
// candidate buckets of both tables (RD) and then decides and writes (CMP). Inserts that find both
// buckets occupied run a displacement chain that is bounded by MAX_KICKS swaps.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   req_*                       request handshake (op, key, insert payload)
//   resp_*                      response handshake (status, key, data), held until accepted
//   hash_key_o, hash_adr0/1_i   key under placement/search and its combinational bucket hashes
//   tN_adr_o, tN_rd_en_o        bucket address and read strobe (read data returns next cycle)
//   tN_wr_en_o, tN_wr_*_o       write strobe and write word, committed at the clock edge
//   tN_rd_*_i                   read word from table N
module cuckoo_access_controller #(
  parameter int unsigned KEY_WIDTH      = 8,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned HASH_ADR_WIDTH = 4,
  parameter int unsigned MAX_KICKS      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [1:0]                req_op_i,
  input  logic [KEY_WIDTH-1:0]      req_key_i,
  input  logic [DATA_WIDTH-1:0]     req_data_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [1:0]                resp_status_o,
  output logic [KEY_WIDTH-1:0]      resp_key_o,
  output logic [DATA_WIDTH-1:0]     resp_data_o,
  output logic [KEY_WIDTH-1:0]      hash_key_o,
  input  logic [HASH_ADR_WIDTH-1:0] hash_adr0_i,
  input  logic [HASH_ADR_WIDTH-1:0] hash_adr1_i,
  output logic [HASH_ADR_WIDTH-1:0] t0_adr_o,
  output logic                      t0_rd_en_o,
  output logic                      t0_wr_en_o,
  output logic [KEY_WIDTH-1:0]      t0_wr_key_o,
  output logic [DATA_WIDTH-1:0]     t0_wr_data_o,
  output logic                      t0_wr_valid_o,
  input  logic [KEY_WIDTH-1:0]      t0_rd_key_i,
  input  logic [DATA_WIDTH-1:0]     t0_rd_data_i,
  input  logic                      t0_rd_valid_i,
  output logic [HASH_ADR_WIDTH-1:0] t1_adr_o,
  output logic                      t1_rd_en_o,
  output logic                      t1_wr_en_o,
  output logic [KEY_WIDTH-1:0]      t1_wr_key_o,
  output logic [DATA_WIDTH-1:0]     t1_wr_data_o,
  output logic                      t1_wr_valid_o,
  input  logic [KEY_WIDTH-1:0]      t1_rd_key_i,
  input  logic [DATA_WIDTH-1:0]     t1_rd_data_i,
  input  logic                      t1_rd_valid_i
);

  localparam int unsigned KickW = $clog2(MAX_KICKS + 1);

  localparam logic [1:0] OpLookup = 2'b00;
  localparam logic [1:0] OpInsert = 2'b01;
  localparam logic [1:0] OpDelete = 2'b10;
  localparam logic [1:0] OpBad    = 2'b11;

  localparam logic [1:0] StsOk    = 2'b00;
  localparam logic [1:0] StsMiss  = 2'b01;
  localparam logic [1:0] StsFull  = 2'b10;
  localparam logic [1:0] StsBadOp = 2'b11;

  typedef enum logic [1:0] {StIdle, StRd, StCmp, StResp} state_e;

  state_e                    state_q;
  logic [1:0]                op_q;
  logic [KEY_WIDTH-1:0]      cur_key_q;
  logic [DATA_WIDTH-1:0]     cur_data_q;
  logic [HASH_ADR_WIDTH-1:0] adr0_q, adr1_q;
  logic                      way_q;
  logic [KickW-1:0]          kick_q;
  logic                      ready_q;
  logic                      resp_valid_q;
  logic [1:0]                resp_status_q;
  logic [KEY_WIDTH-1:0]      resp_key_q;
  logic [DATA_WIDTH-1:0]     resp_data_q;

  // CMP-stage decision
  logic                      match0, match1;
  logic                      cmp_done;
  logic [1:0]                cmp_status;
  logic [DATA_WIDTH-1:0]     cmp_data;
  logic                      wr0_sel, wr1_sel;
  logic                      wr_valid;
  logic [KEY_WIDTH-1:0]      old_key;
  logic [DATA_WIDTH-1:0]     old_data;
  logic [KickW-1:0]          kick_next;

  assign kick_next = kick_q + KickW'(1);

  // When a swap happens, the evicted entry comes from whichever table is being written.
  assign old_key  = wr1_sel ? t1_rd_key_i  : t0_rd_key_i;
  assign old_data = wr1_sel ? t1_rd_data_i : t0_rd_data_i;

  always_comb begin
    match0     = t0_rd_valid_i && (t0_rd_key_i == cur_key_q);
    match1     = t1_rd_valid_i && (t1_rd_key_i == cur_key_q);
    cmp_done   = 1'b0;
    cmp_status = StsOk;
    cmp_data   = cur_data_q;
    wr0_sel    = 1'b0;
    wr1_sel    = 1'b0;
    wr_valid   = 1'b1;
    if (kick_q == '0) begin
      case (op_q)
        OpLookup: begin
          cmp_done = 1'b1;
          if (match0)      cmp_data = t0_rd_data_i;
          else if (match1) cmp_data = t1_rd_data_i;
          else             cmp_status = StsMiss;
        end
        OpDelete: begin
          cmp_done = 1'b1;
          wr_valid = 1'b0;
          if (match0)      wr0_sel = 1'b1;
          else if (match1) wr1_sel = 1'b1;
          else             cmp_status = StsMiss;
        end
        OpInsert: begin
          if (match0) begin
            wr0_sel  = 1'b1;
            cmp_done = 1'b1;
          end else if (match1) begin
            wr1_sel  = 1'b1;
            cmp_done = 1'b1;
          end else if (!t0_rd_valid_i) begin
            wr0_sel  = 1'b1;
            cmp_done = 1'b1;
          end else if (!t1_rd_valid_i) begin
            wr1_sel  = 1'b1;
            cmp_done = 1'b1;
          end else begin
            wr0_sel  = 1'b1;  // both full: first swap always goes into T0
          end
        end
        default: begin
          cmp_done   = 1'b1;
          cmp_status = StsBadOp;
        end
      endcase
    end else if (!way_q) begin
      // Kick pass: only table `way` is considered, no key match.
      wr0_sel  = 1'b1;
      cmp_done = !t0_rd_valid_i;
    end else begin
      wr1_sel  = 1'b1;
      cmp_done = !t1_rd_valid_i;
    end
  end

  // Memory-side strobes, decoded from the current state.
  always_comb begin
    t0_adr_o      = '0;
    t1_adr_o      = '0;
    t0_rd_en_o    = 1'b0;
    t1_rd_en_o    = 1'b0;
    t0_wr_en_o    = 1'b0;
    t1_wr_en_o    = 1'b0;
    t0_wr_key_o   = '0;
    t0_wr_data_o  = '0;
    t0_wr_valid_o = 1'b0;
    t1_wr_key_o   = '0;
    t1_wr_data_o  = '0;
    t1_wr_valid_o = 1'b0;
    case (state_q)
      StRd: begin
        t0_adr_o   = hash_adr0_i;
        t1_adr_o   = hash_adr1_i;
        t0_rd_en_o = 1'b1;
        t1_rd_en_o = 1'b1;
      end
      StCmp: begin
        t0_adr_o = adr0_q;
        t1_adr_o = adr1_q;
        if (wr0_sel) begin
          t0_wr_en_o    = 1'b1;
          t0_wr_key_o   = cur_key_q;
          t0_wr_data_o  = cur_data_q;
          t0_wr_valid_o = wr_valid;
        end
        if (wr1_sel) begin
          t1_wr_en_o    = 1'b1;
          t1_wr_key_o   = cur_key_q;
          t1_wr_data_o  = cur_data_q;
          t1_wr_valid_o = wr_valid;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      op_q          <= OpLookup;
      cur_key_q     <= '0;
      cur_data_q    <= '0;
      adr0_q        <= '0;
      adr1_q        <= '0;
      way_q         <= 1'b0;
      kick_q        <= '0;
      ready_q       <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_status_q <= StsOk;
      resp_key_q    <= '0;
      resp_data_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid_i && ready_q) begin
            op_q       <= req_op_i;
            cur_key_q  <= req_key_i;
            cur_data_q <= req_data_i;
            kick_q     <= '0;
            way_q      <= 1'b0;
            ready_q    <= 1'b0;
            if (req_op_i == OpBad) begin
              state_q       <= StResp;
              resp_valid_q  <= 1'b1;
              resp_status_q <= StsBadOp;
              resp_key_q    <= req_key_i;
              resp_data_q   <= req_data_i;
            end else begin
              state_q <= StRd;
            end
          end else begin
            ready_q <= 1'b1;  // first idle cycle after reset raises ready
          end
        end
        StRd: begin
          adr0_q  <= hash_adr0_i;
          adr1_q  <= hash_adr1_i;
          state_q <= StCmp;
        end
        StCmp: begin
          if (cmp_done) begin
            state_q       <= StResp;
            resp_valid_q  <= 1'b1;
            resp_status_q <= cmp_status;
            resp_key_q    <= cur_key_q;
            resp_data_q   <= cmp_data;
          end else begin
            cur_key_q  <= old_key;
            cur_data_q <= old_data;
            way_q      <= ~wr1_sel;
            kick_q     <= kick_next;
            if (kick_next == KickW'(MAX_KICKS)) begin
              state_q       <= StResp;
              resp_valid_q  <= 1'b1;
              resp_status_q <= StsFull;
              resp_key_q    <= old_key;
              resp_data_q   <= old_data;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StResp: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o   = ready_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_status_o = resp_status_q;
  assign resp_key_o    = resp_key_q;
  assign resp_data_o   = resp_data_q;
  assign hash_key_o    = cur_key_q;

endmodule

// File: tb/tb_cuckoo_access_controller.sv
// Self-checking bench for cuckoo_access_controller. The bench owns both table memories and the
// hash functions (lookup tables per key), keeps an independent model of the hash tables, and
// compares responses, latency and final table contents against it.
module tb_cuckoo_access_controller;

  localparam int MAXK = 4;

  typedef struct packed {
    logic       v;
    logic [7:0] k;
    logic [7:0] d;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, resp_valid, resp_ready;
  logic [1:0] req_op, resp_status;
  logic [7:0] req_key, req_data, resp_key, resp_data, hash_key;
  logic [3:0] hash_adr0, hash_adr1;
  logic [3:0] t0_adr, t1_adr;
  logic       t0_rd_en, t0_wr_en, t0_wr_valid, t1_rd_en, t1_wr_en, t1_wr_valid;
  logic [7:0] t0_wr_key, t0_wr_data, t1_wr_key, t1_wr_data;

  ent_t       mem0 [16];
  ent_t       mem1 [16];
  ent_t       mod0 [16];
  ent_t       mod1 [16];
  ent_t       rd0_q, rd1_q;
  logic [3:0] h0_tab [256];
  logic [3:0] h1_tab [256];
  logic       clr_mem;

  int         total = 0;
  int         bad = 0;

  // Expectations produced by the model for the operation in flight
  logic       exp_active = 1'b0;
  logic [1:0] exp_status;
  logic [7:0] exp_key, exp_data;
  logic       exp_chkdata;
  int         exp_lat;

  // Observations from the last completed operation
  logic [1:0] last_status;
  logic [7:0] last_key, last_data;
  int         last_lat;

  int         lat = 0;
  int         acc_id = 0;
  int         chk_id = 0;

  always #5 clk = ~clk;

  assign hash_adr0 = h0_tab[hash_key];
  assign hash_adr1 = h1_tab[hash_key];

  cuckoo_access_controller #(
    .KEY_WIDTH(8), .DATA_WIDTH(8), .HASH_ADR_WIDTH(4), .MAX_KICKS(MAXK)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_key_i(req_key), .req_data_i(req_data),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_status_o(resp_status),
    .resp_key_o(resp_key), .resp_data_o(resp_data),
    .hash_key_o(hash_key), .hash_adr0_i(hash_adr0), .hash_adr1_i(hash_adr1),
    .t0_adr_o(t0_adr), .t0_rd_en_o(t0_rd_en), .t0_wr_en_o(t0_wr_en),
    .t0_wr_key_o(t0_wr_key), .t0_wr_data_o(t0_wr_data), .t0_wr_valid_o(t0_wr_valid),
    .t0_rd_key_i(rd0_q.k), .t0_rd_data_i(rd0_q.d), .t0_rd_valid_i(rd0_q.v),
    .t1_adr_o(t1_adr), .t1_rd_en_o(t1_rd_en), .t1_wr_en_o(t1_wr_en),
    .t1_wr_key_o(t1_wr_key), .t1_wr_data_o(t1_wr_data), .t1_wr_valid_o(t1_wr_valid),
    .t1_rd_key_i(rd1_q.k), .t1_rd_data_i(rd1_q.d), .t1_rd_valid_i(rd1_q.v)
  );

  // Single-port table memories, one-cycle read latency
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 16; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      if (t0_rd_en) rd0_q <= mem0[t0_adr];
      if (t1_rd_en) rd1_q <= mem1[t1_adr];
      if (t0_wr_en) mem0[t0_adr] <= {t0_wr_valid, t0_wr_key, t0_wr_data};
      if (t1_wr_en) mem1[t1_adr] <= {t1_wr_valid, t1_wr_key, t1_wr_data};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  function automatic logic same_ent(input ent_t a, input ent_t b);
    return (a.v == b.v) && (!a.v || (a.k == b.k && a.d == b.d));
  endfunction

  task automatic mem_check();
    int bad0 = -1;
    int bad1 = -1;
    for (int i = 0; i < 16; i++) begin
      if (bad0 < 0 && !same_ent(mem0[i], mod0[i])) bad0 = i;
      if (bad1 < 0 && !same_ent(mem1[i], mod1[i])) bad1 = i;
    end
    check("t0_contents_first_bad_idx", bad0, -1);
    check("t1_contents_first_bad_idx", bad1, -1);
  endtask

  // Reference model: the effect of one request on the tables, plus the response it must produce.
  task automatic model_exec(input logic [1:0] op, input logic [7:0] k, input logic [7:0] d);
    logic [3:0] a0, a1, a;
    ent_t       cur, old;
    int         way, kicks;
    logic       fin;
    a0 = h0_tab[k];
    a1 = h1_tab[k];
    exp_key     = k;
    exp_data    = d;
    exp_chkdata = 1'b0;
    exp_lat     = 3;
    exp_status  = 2'd0;
    case (op)
      2'd0: begin
        exp_chkdata = 1'b1;
        if (mod0[a0].v && mod0[a0].k == k)      exp_data = mod0[a0].d;
        else if (mod1[a1].v && mod1[a1].k == k) exp_data = mod1[a1].d;
        else begin
          exp_status  = 2'd1;
          exp_chkdata = 1'b0;
        end
      end
      2'd2: begin
        if (mod0[a0].v && mod0[a0].k == k)      mod0[a0].v = 1'b0;
        else if (mod1[a1].v && mod1[a1].k == k) mod1[a1].v = 1'b0;
        else                                    exp_status = 2'd1;
      end
      2'd1: begin
        if (mod0[a0].v && mod0[a0].k == k)      mod0[a0].d = d;
        else if (mod1[a1].v && mod1[a1].k == k) mod1[a1].d = d;
        else if (!mod0[a0].v)                   mod0[a0] = '{1'b1, k, d};
        else if (!mod1[a1].v)                   mod1[a1] = '{1'b1, k, d};
        else begin
          cur   = '{1'b1, k, d};
          way   = 0;
          kicks = 0;
          fin   = 1'b0;
          while (!fin) begin
            a = (way == 0) ? h0_tab[cur.k] : h1_tab[cur.k];
            if (way == 0) begin old = mod0[a]; mod0[a] = cur; end
            else          begin old = mod1[a]; mod1[a] = cur; end
            cur = old;
            kicks++;
            if (kicks == MAXK) begin
              exp_status  = 2'd2;
              exp_key     = cur.k;
              exp_data    = cur.d;
              exp_chkdata = 1'b1;
              exp_lat     = 1 + 2 * MAXK;
              fin         = 1'b1;
            end else begin
              way = 1 - way;
              a = (way == 0) ? h0_tab[cur.k] : h1_tab[cur.k];
              if (way == 0 && !mod0[a].v) begin mod0[a] = cur; fin = 1'b1; end
              if (way == 1 && !mod1[a].v) begin mod1[a] = cur; fin = 1'b1; end
              if (fin) begin
                exp_key = cur.k;
                exp_lat = 3 + 2 * kicks;
              end
            end
          end
        end
      end
      default: begin
        exp_status = 2'd3;
        exp_lat    = 1;
      end
    endcase
  endtask

  task automatic do_op(input logic [1:0] op, input logic [7:0] k, input logic [7:0] d,
                       input int stall);
    int n;
    model_exec(op, k, d);
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("ready_wait", {31'd0, req_ready}, 1);
    if (!req_ready) return;
    exp_active = 1'b1;
    req_valid = 1'b1;
    req_op    = op;
    req_key   = k;
    req_data  = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 100) begin @(posedge clk); #1; n++; end
    last_lat = n;
    check("resp_wait", {31'd0, resp_valid}, 1);
    if (!resp_valid) begin
      exp_active = 1'b0;
      return;
    end
    last_status = resp_status;
    last_key    = resp_key;
    last_data   = resp_data;
    repeat (stall) begin @(posedge clk); #1; end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    exp_active = 1'b0;
    mem_check();
  endtask

  task automatic clear_all();
    clr_mem = 1'b1;
    @(posedge clk); #1;
    clr_mem = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mod0[i] = '0;
      mod1[i] = '0;
    end
  endtask

  task automatic default_hash();
    for (int i = 0; i < 256; i++) begin
      h0_tab[i] = 4'(i);
      h1_tab[i] = 4'(i >> 4);
    end
  endtask

  function automatic logic all_out_or();
    return |{req_ready, resp_valid, resp_status, resp_key, resp_data, hash_key,
             t0_adr, t0_rd_en, t0_wr_en, t0_wr_key, t0_wr_data, t0_wr_valid,
             t1_adr, t1_rd_en, t1_wr_en, t1_wr_key, t1_wr_data, t1_wr_valid};
  endfunction

  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'd0;
    req_key    = 8'd0;
    req_data   = 8'd0;
    resp_ready = 1'b0;
    clr_mem    = 1'b1;
    default_hash();
    for (int i = 0; i < 16; i++) begin
      mod0[i] = '0;
      mod1[i] = '0;
    end

    fork
      // Latency tracker: cycles since the last accepted request
      forever begin
        @(posedge clk);
        if (req_valid && req_ready) begin
          lat = 1;
          acc_id++;
        end else begin
          lat++;
        end
      end
      // Per-cycle response comparison against the model
      forever begin
        @(negedge clk);
        if (reset) begin
          if (resp_valid) begin
            if (!exp_active) begin
              check("unexpected_resp", {31'd0, resp_valid}, 0);
            end else begin
              if (chk_id != acc_id) begin
                check("resp_latency", lat, exp_lat);
                chk_id = acc_id;
              end
              check("resp_status", {30'd0, resp_status}, {30'd0, exp_status});
              check("resp_key", {24'd0, resp_key}, {24'd0, exp_key});
              if (exp_chkdata) check("resp_data", {24'd0, resp_data}, {24'd0, exp_data});
              check("quiet_in_resp", {28'd0, t0_rd_en, t1_rd_en, t0_wr_en, t1_wr_en}, 0);
              check("ready_low_in_resp", {31'd0, req_ready}, 0);
            end
          end
          if (exp_active && exp_status == 2'd3)
            check("badop_no_mem", {28'd0, t0_rd_en, t1_rd_en, t0_wr_en, t1_wr_en}, 0);
        end
      end
    join_none

    // Reset behaviour
    repeat (3) @(posedge clk);
    #1;
    clr_mem = 1'b0;
    check("reset_outputs_zero", {31'd0, all_out_or()}, 0);
    reset = 1'b1;
    check("ready_low_at_release", {31'd0, req_ready}, 0);
    @(posedge clk); #1;
    check("ready_after_reset", {31'd0, req_ready}, 1);

    // Insert / lookup / update / delete on T0[3]
    h0_tab[8'h12] = 4'd3;
    do_op(2'd1, 8'h12, 8'hA5, 0);
    check("ins12_status", last_status, 0);
    check("ins12_lat", last_lat, 3);
    check("ins12_t0_3", mem0[3], 32'h1_12A5);
    do_op(2'd0, 8'h12, 8'h00, 0);
    check("lkp12_status", last_status, 0);
    check("lkp12_data", last_data, 32'hA5);
    do_op(2'd1, 8'h12, 8'h77, 0);
    check("upd12_t0_3", mem0[3], 32'h1_1277);
    do_op(2'd0, 8'h12, 8'h00, 0);
    check("lkp12b_data", last_data, 32'h77);
    do_op(2'd2, 8'h12, 8'h00, 0);
    check("del12_status", last_status, 0);
    check("del12_valid", mem0[3].v, 0);
    do_op(2'd2, 8'h12, 8'h00, 0);
    check("del12_again_status", last_status, 1);

    // Second-table placement and a single swap
    h0_tab[8'h20] = 4'd3; h1_tab[8'h20] = 4'd7;
    h0_tab[8'h30] = 4'd3; h1_tab[8'h30] = 4'd5;
    h0_tab[8'h40] = 4'd3; h1_tab[8'h40] = 4'd5;
    do_op(2'd1, 8'h20, 8'h01, 0);
    do_op(2'd1, 8'h30, 8'h02, 0);
    check("ins30_lat", last_lat, 3);
    check("ins30_t1_5", mem1[5], 32'h1_3002);
    do_op(2'd1, 8'h40, 8'h03, 0);
    check("ins40_status", last_status, 0);
    check("ins40_lat", last_lat, 5);
    check("ins40_key", last_key, 32'h20);
    check("ins40_t0_3", mem0[3], 32'h1_4003);
    check("ins40_t1_7", mem1[7], 32'h1_2001);

    // Cyclic collision set: chain exhausts MAX_KICKS
    clear_all();
    for (int i = 8'h51; i <= 8'h54; i++) begin
      h0_tab[i] = 4'd8;
      h1_tab[i] = 4'd9;
    end
    do_op(2'd1, 8'h51, 8'h11, 0);
    do_op(2'd1, 8'h52, 8'h22, 0);
    do_op(2'd1, 8'h53, 8'h33, 0);
    check("full_status", last_status, 2);
    check("full_lat", last_lat, 9);
    check("full_key", last_key, 32'h51);
    check("full_data", last_data, 32'h11);
    check("full_t0_8", mem0[8], 32'h1_5222);
    check("full_t1_9", mem1[9], 32'h1_5333);

    // Reserved op and a stalled response
    do_op(2'd3, 8'h66, 8'h99, 0);
    check("badop_status", last_status, 3);
    check("badop_lat", last_lat, 1);
    do_op(2'd0, 8'h52, 8'h00, 5);
    check("stall_lkp_data", last_data, 32'h22);

    // Reset in the middle of a kick chain
    req_valid = 1'b1;
    req_op    = 2'd1;
    req_key   = 8'h54;
    req_data  = 8'h44;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midchain_reset_outputs", {31'd0, all_out_or()}, 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("midchain_no_resp", {31'd0, resp_valid}, 0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check("midchain_ready_back", {31'd0, req_ready}, 1);
    clear_all();

    // Randomized traffic on a small key pool to force collisions and chains
    default_hash();
    for (int n = 0; n < 300; n++) begin
      int         r;
      logic [1:0] op;
      logic [7:0] k;
      r  = $urandom_range(0, 19);
      op = (r < 9) ? 2'd1 : (r < 16) ? 2'd0 : (r < 19) ? 2'd2 : 2'd3;
      k  = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      do_op(op, k, 8'($urandom), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
